// File: rtl/hw_stack_pkg.sv
// rtl/hw_stack_pkg.sv - shared defaults and operation decode for the hardware operand stack
package hw_stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    // One operation per cycle, decoded from the push/pop pair.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        REPLACE = 2'd3
    } op_e;

    function automatic op_e decode_op(input logic push, input logic pop);
        if (push && pop) return REPLACE;
        if (push)        return PUSH;
        if (pop)         return POP;
        return IDLE;
    endfunction

endpackage

// File: rtl/hw_stack_ram.sv
// rtl/hw_stack_ram.sv - storage for the entries below top-of-stack, sync write / async read
//
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address (combinational read)
//   rdata  - read data
module hw_stack_ram #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 15,
    parameter int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; count in the parent marks what is valid.
    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hw_stack.sv
// rtl/hw_stack.sv - show-ahead LIFO operand stack with status, sticky errors and high-water mark
//
// Ports:
//   clk           - clock, rising edge
//   resetN        - synchronous active-low reset
//   push, pop     - stack operations; both together replace the top entry
//   data_in       - word to push
//   data_out      - registered top of stack, 0 when empty
//   full, empty   - decodes of count
//   count         - number of valid entries
//   overflow_err  - sticky, push refused while full
//   underflow_err - sticky, pop attempted while empty
//   err_clear     - clears both sticky flags (a same-cycle error wins)
//   high_water    - maximum count since reset
module hw_stack
    import hw_stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow_err,
    output logic             underflow_err,
    input  logic             err_clear,
    output logic [CW-1:0]    high_water
);

    localparam int ENTRIES = DEPTH - 1;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [WIDTH-1:0] top_q, top_d;
    logic [CW-1:0]    count_d;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic             ovf_set, unf_set;
    op_e              op;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // T spills into S[count-1] on push; S[count-2] is the entry that rises on pop.
    // Addresses are only used when count makes them valid.
    assign ram_waddr = AW'(count - CW'(1));
    assign ram_raddr = AW'(count - CW'(2));

    hw_stack_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (top_q),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        op      = decode_op(push, pop);
        top_d   = top_q;
        count_d = count;
        ram_we  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (op)
            PUSH: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    ram_we  = !empty;
                    top_d   = data_in;
                    count_d = count + CW'(1);
                end
            end
            POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else if (count == CW'(1)) begin
                    top_d   = '0;
                    count_d = '0;
                end else begin
                    top_d   = ram_rdata;
                    count_d = count - CW'(1);
                end
            end
            REPLACE: begin
                // On an empty stack the push half still happens; only the pop half is refused.
                top_d = data_in;
                if (empty) begin
                    count_d = CW'(1);
                    unf_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            top_q         <= '0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            high_water    <= '0;
        end else begin
            top_q         <= top_d;
            count         <= count_d;
            overflow_err  <= ovf_set | (overflow_err & ~err_clear);
            underflow_err <= unf_set | (underflow_err & ~err_clear);
            if (count_d > high_water) begin
                high_water <= count_d;
            end
        end
    end

    assign data_out = top_q;

endmodule

// File: tb/tb_hw_stack.sv
// tb/tb_hw_stack.sv - scoreboard bench for hw_stack against a queue-based reference stack
module tb_hw_stack;
    import hw_stack_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             resetN = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             err_clear = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             full, empty, overflow_err, underflow_err;
    logic [CW-1:0]    count, high_water;

    hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .push          (push),
        .pop           (pop),
        .data_in       (data_in),
        .data_out      (data_out),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .err_clear     (err_clear),
        .high_water    (high_water)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int cnt;
        int full;
        int empty;
        int ovf;
        int unf;
        int hw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    // Reference model: a plain queue whose back is the top of stack.
    int m_stk[$];
    int m_ovf = 0;
    int m_unf = 0;
    int m_hw  = 0;

    task automatic model_step(input logic rn, input logic p, input logic q,
                              input int d, input logic clr);
        op_e op;
        int  o_set, u_set;
        if (!rn) begin
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
            m_hw  = 0;
            return;
        end
        op    = decode_op(p, q);
        o_set = 0;
        u_set = 0;
        case (op)
            PUSH:    if (m_stk.size() == DEPTH) o_set = 1; else m_stk.push_back(d);
            POP:     if (m_stk.size() == 0) u_set = 1; else void'(m_stk.pop_back());
            REPLACE: begin
                if (m_stk.size() == 0) begin
                    u_set = 1;
                    m_stk.push_back(d);
                end else begin
                    m_stk[m_stk.size() - 1] = d;
                end
            end
            default: ;
        endcase
        m_ovf = (o_set != 0 || (m_ovf != 0 && !clr)) ? 1 : 0;
        m_unf = (u_set != 0 || (m_unf != 0 && !clr)) ? 1 : 0;
        if (m_stk.size() > m_hw) m_hw = m_stk.size();
    endtask

    task automatic cyc(input logic rn, input logic p, input logic q,
                       input int d, input logic clr);
        exp_t e;
        @(negedge clk);
        resetN    = rn;
        push      = p;
        pop       = q;
        data_in   = WIDTH'(d);
        err_clear = clr;
        model_step(rn, p, q, d, clr);
        e.data  = (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 0;
        e.cnt   = m_stk.size();
        e.full  = (m_stk.size() == DEPTH) ? 1 : 0;
        e.empty = (m_stk.size() == 0) ? 1 : 0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.hw    = m_hw;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: each cycle the DUT presents its state just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data_out",      int'(data_out),      e.data);
                chk("count",         int'(count),         e.cnt);
                chk("full",          int'(full),          e.full);
                chk("empty",         int'(empty),         e.empty);
                chk("overflow_err",  int'(overflow_err),  e.ovf);
                chk("underflow_err", int'(underflow_err), e.unf);
                chk("high_water",    int'(high_water),    e.hw);
            end
        end
    end

    initial begin
        int pp;
        bit p, q;
        // Reset
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Push three, then pop them back out
        cyc(1, 1, 0, 'h11, 0);
        cyc(1, 1, 0, 'h22, 0);
        cyc(1, 1, 0, 'h33, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        // Fill, overflow, clear
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, i, 0);
        cyc(1, 1, 0, 'hAA, 0);
        cyc(1, 0, 0, 0, 1);
        // Replace while full, then pop
        cyc(1, 1, 1, 'h5C, 0);
        cyc(1, 0, 1, 0, 0);
        // Drain, underflow, clear racing a new underflow
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1);
        // Push+pop on empty stack
        cyc(1, 1, 1, 'h77, 0);
        // Reset mid-burst with a push
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 'h40 + i, 0);
        cyc(0, 1, 0, 'h99, 0);
        cyc(1, 0, 0, 0, 0);
        // Randomized phases with varying push bias
        for (int blk = 0; blk < 12; blk++) begin
            pp = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 20 : 50);
            for (int i = 0; i < 50; i++) begin
                p = ($urandom_range(99) < pp);
                q = ($urandom_range(99) < (100 - pp));
                cyc(($urandom_range(99) != 0), p, q, int'($urandom_range(255)),
                    ($urandom_range(9) == 0));
            end
        end
        cyc(1, 0, 0, 0, 0);
        stim_done = 1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hw_stack.md
Name: hw_stack

Overview:
- LIFO operand stack that serves the multicycle stack processor.
- The processor drives push/pop and write data; this block returns the top-of-stack value, full/empty status and sticky error flags.
- Show-ahead: top of stack is always on data_out. The processor samples it in the cycle after asserting pop, and reads successive elements by holding pop high for consecutive cycles (add/sub operands).

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, maximum number of entries; must be >= 2.
- CW, $clog2(DEPTH+1), width of the count and high_water outputs; derived, not overridden.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- resetN  input  1  reset, synchronous, active-low.
- push  input  1  push data_in this cycle.
- pop  input  1  remove top entry this cycle.
- data_in  input  WIDTH  word to push.
- data_out  output  WIDTH  current top of stack (registered); 0 when empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  CW  number of valid entries.
- overflow_err  output  1  sticky: push refused because the stack was full.
- underflow_err  output  1  sticky: pop refused because the stack was empty.
- err_clear  input  1  clears both sticky error flags.
- high_water  output  CW  maximum count reached since reset.

Behaviour:
- Reset (resetN=0 at a clk edge): count=0, data_out=0, overflow_err=0, underflow_err=0, high_water=0. full=0 and empty=1 follow from count. Storage array contents are not reset. Reset overrides any push/pop in the same cycle, including mid-burst.
- Structure: top register T drives data_out. Array S[0..DEPTH-2] holds the entries below it, where S[count-2] is the entry directly under T.
- full and empty are combinational decodes of the count register.
- push only, not full: S[count-1]<=T (only when count>=1), T<=data_in, count+1. The new value is visible on data_out in the next cycle.
- push only, full: no state change; overflow_err<=1.
- pop only, count>=2: T<=S[count-2], count-1.
- pop only, count==1: T<=0, count<=0.
- pop only, empty: no state change; underflow_err<=1.
- push and pop together, count>=1: replace top. T<=data_in, count unchanged, no error even when full.
- push and pop together, empty: the push is performed (T<=data_in, count=1); underflow_err<=1.
- Idle (neither push nor pop): all state holds.
- Latency: data_out reflects an operation 1 cycle after the edge that performs it. Holding pop for N cycles presents N successive older entries, one per cycle.
- err_clear: both flags <=0. If a new error occurs in the same cycle, set wins for that flag.
- high_water: updates to the next count whenever the next count exceeds the current high_water; never decreases except on reset.
- Entries only move between T and S; no arithmetic on data. Count arithmetic never wraps, because refused operations leave count unchanged.

Decomposition:
- Shared package: the WIDTH and DEPTH defaults, and an op-code enum {IDLE, PUSH, POP, REPLACE} used for internal decode and by the bench scoreboard.
- One natural sub-module, stack_ram:
  - DEPTH-1 x WIDTH synchronous-write, asynchronous-read array with single write and single read ports.
  - hw_stack holds T, count, the flags and high_water.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> data_out 0x11, 0x22, 0x33 one cycle after each push; count=3; empty=0; high_water=3.
- From that state, hold pop for 2 cycles -> data_out shows 0x22, then 0x11; count=1; then one more pop -> data_out=0x00, empty=1, high_water still 3.
- Push 16 values 0x00..0x0F, then push 0xAA -> full=1, count=16, data_out=0x0F, overflow_err=1. Assert err_clear for 1 cycle -> overflow_err=0.
- Empty stack, pop -> underflow_err=1, count=0, data_out=0. Then err_clear together with another pop -> underflow_err stays 1.
- count=16 with top 0x0F, assert push+pop with data_in 0x5C -> count=16, data_out=0x5C, no overflow. Next pop -> data_out=0x0E.
- Mid-sequence (count=5), drive resetN=0 together with push -> next cycle count=0, data_out=0, flags=0, high_water=0.
